reg_xfer_issuer: RTL and testbench

Control-side issuer for the datapath register-transfer strobes. Accepts register-transfer commands over a valid/ready handshake, buffers them in a small FIFO, and for each command drives bus2 data and the `rdAC`/`wr`/`en` strobe triple of one destination register. These are the destination-register controls that the datapath registers sample on the falling clock edge. The issuer is the initiating end of that register-load protocol and sits between the instruction decoder and the datapath register bank.

---
 rtl/reg_xfer_if.sv | 29 ++
 rtl/reg_xfer_issuer.sv | 123 ++++++++++++
 tb/tb_reg_xfer_issuer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_if.sv
// Command handshake and register-transfer strobe bundle between the decoder
// side (master) and the issuer (slave).
interface reg_xfer_if #(
  parameter int NREG = 4,
  parameter int DW   = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [1:0]      cmd_dst;
  logic [DW-1:0]   cmd_data;
  logic [NREG-1:0] rdAC_o;
  logic [NREG-1:0] wr_o;
  logic [NREG-1:0] en_o;
  logic [DW-1:0]   bus2_o;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_data,
    input  cmd_ready, rdAC_o, wr_o, en_o, bus2_o, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_data,
    output cmd_ready, rdAC_o, wr_o, en_o, bus2_o, busy, done, err
  );
endinterface

// File: rtl/reg_xfer_issuer.sv
// Register-transfer issuer: queues commands and drives bus2 plus one
// destination register's rdAC/wr/en triple per command (IDLE/SETUP/STROBE/HOLD).

// One destination register's strobe triple, registered.
module reg_xfer_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic [1:0] op,
  output logic       rdac,
  output logic       wr,
  output logic       en
);
  always_ff @(posedge clk) begin
    if (rst) begin
      rdac <= 1'b0;
      wr   <= 1'b0;
      en   <= 1'b0;
    end else begin
      // LOAD=011, STORE=100, MOVE=111, NOP=000
      rdac <= fire && op[1];
      wr   <= fire && op[0];
      en   <= fire && op[0];
    end
  end
endmodule

module reg_xfer_issuer #(
  parameter int NREG  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  reg_xfer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_STORE, OP_MOVE} op_t;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef struct packed {
    logic [1:0]    op;
    logic [1:0]    dst;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW:0]     wptr, rptr;
  logic            full, empty, push, pop, nxt_nonempty;
  state_t          state, nxt_state;
  logic [1:0]      cur_op, cur_dst;
  logic [NREG-1:0] fire_v, rd_v, wr_v, en_v;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

  // No full-bypass: a full FIFO refuses the push even on a popping cycle.
  assign bus.cmd_ready = !full && !rst;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = !empty && (state == IDLE || state == HOLD);
  assign nxt_nonempty = (wptr + (push ? ONE : '0)) != (rptr + (pop ? ONE : '0));

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (!empty) nxt_state = SETUP;
      SETUP:   nxt_state = STROBE;
      STROBE:  nxt_state = HOLD;
      HOLD:    nxt_state = empty ? IDLE : SETUP;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      state      <= IDLE;
      cur_op     <= OP_NOP;
      cur_dst    <= '0;
      bus.bus2_o <= '0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= '{op: bus.cmd_op, dst: bus.cmd_dst, data: bus.cmd_data};
        wptr <= wptr + ONE;
        if (int'(bus.cmd_dst) >= NREG) bus.err <= 1'b1;
      end
      if (pop) begin
        rptr    <= rptr + ONE;
        cur_op  <= head.op;
        cur_dst <= head.dst;
        // bus2 changes only on entry to SETUP, so it is stable around the capture edge
        if (head.op == OP_LOAD) bus.bus2_o <= head.data;
      end
      state    <= nxt_state;
      bus.done <= (state == STROBE);
      bus.busy <= (nxt_state != IDLE) || nxt_nonempty;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_lane
    assign fire_v[i] = (state == SETUP) && (cur_dst == 2'(i));
    reg_xfer_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .fire (fire_v[i]),
      .op   (cur_op),
      .rdac (rd_v[i]),
      .wr   (wr_v[i]),
      .en   (en_v[i])
    );
  end

  assign bus.rdAC_o = rd_v;
  assign bus.wr_o   = wr_v;
  assign bus.en_o   = en_v;
endmodule

// File: tb/tb_reg_xfer_issuer.sv
// Drives one command stream into a 4-register and a 2-register issuer and
// scoreboards every completed command against a transaction-level model.
module tb_reg_xfer_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_xfer_if #(.NREG(4), .DW(8)) if4 ();
  reg_xfer_if #(.NREG(2), .DW(8)) if2 ();

  reg_xfer_issuer #(.NREG(4), .DW(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  reg_xfer_issuer #(.NREG(2), .DW(8), .DEPTH(4)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // index 0 = 4-register issuer, index 1 = 2-register issuer
  logic [3:0] s_rd [2], s_wr [2], s_en [2];
  logic [7:0] s_bus [2];
  logic       s_done [2], s_busy [2], s_err [2];
  assign s_rd[0] = if4.rdAC_o;  assign s_rd[1] = {2'b00, if2.rdAC_o};
  assign s_wr[0] = if4.wr_o;    assign s_wr[1] = {2'b00, if2.wr_o};
  assign s_en[0] = if4.en_o;    assign s_en[1] = {2'b00, if2.en_o};
  assign s_bus[0] = if4.bus2_o; assign s_bus[1] = if2.bus2_o;
  assign s_done[0] = if4.done;  assign s_done[1] = if2.done;
  assign s_busy[0] = if4.busy;  assign s_busy[1] = if2.busy;
  assign s_err[0] = if4.err;    assign s_err[1] = if2.err;

  typedef struct packed {
    logic [1:0][3:0] rd, wr, en;
    logic [7:0]      bus;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_load = 8'h00;
  logic [1:0] err_exp = 2'b00;
  logic [7:0] mreg [4];
  int         last_stb = 0, prev_stb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected {rdAC, wr, en} vectors for one command on an nr-register issuer.
  function automatic logic [11:0] trip(logic [1:0] op, logic [1:0] dst, int nr);
    logic [3:0] b;
    b = 4'b0001 << dst;
    if (op == 2'd0 || int'(dst) >= nr) return 12'h000;
    case (op)
      2'd1:    return {4'b0000, b, b};
      2'd2:    return {b, 4'b0000, 4'b0000};
      default: return {b, b, b};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] dst, input logic [7:0] data);
    if4.cmd_valid = v; if4.cmd_op = op; if4.cmd_dst = dst; if4.cmd_data = data;
    if2.cmd_valid = v; if2.cmd_op = op; if2.cmd_dst = dst; if2.cmd_data = data;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] dst, input logic [7:0] data, output int acc);
    bit ok;
    exp_t e;
    logic [11:0] t;
    ok = 1'b0;
    acc = -1;
    @(negedge clk);
    drive(1'b1, op, dst, data);
    for (int w = 0; w < 100 && !ok; w++) begin
      #1;
      chk("ready_match", if2.cmd_ready, if4.cmd_ready);
      if (if4.cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else @(negedge clk);
    end
    drive(1'b0, 2'd0, 2'd0, 8'h00);
    if (!ok) chk("push_timeout", 0, 1);
    else begin
      acc = cyc;
      if (op == 2'd1) last_load = data;
      for (int d = 0; d < 2; d++) begin
        t = trip(op, dst, d == 0 ? 4 : 2);
        e.rd[d] = t[11:8]; e.wr[d] = t[7:4]; e.en[d] = t[3:0];
        if (int'(dst) >= (d == 0 ? 4 : 2)) err_exp[d] = 1'b1;
      end
      e.bus = last_load;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 8'h00);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 8'h00);
    for (int w = 0; w < 300; w++) begin
      if (q.size() == 0 && !if4.busy) break;
      @(negedge clk);
    end
    chk("drain", (q.size() == 0) && !if4.busy, 1);
  endtask

  // Called at a negedge: holds rst across one edge, checks the reset state, releases.
  task automatic rst_body();
    rst = 1'b1;
    drive(1'b0, 2'd0, 2'd0, 8'h00);
    @(posedge clk); #1;
    q.delete();
    last_load = 8'h00;
    err_exp = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_strobes", s_rd[d] | s_wr[d] | s_en[d], 0);
      chk("rst_bus2", s_bus[d], 0);
      chk("rst_done", s_done[d], 0);
      chk("rst_busy", s_busy[d], 0);
      chk("rst_err", s_err[d], 0);
    end
    chk("rst_ready_low", if4.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst4", if4.cmd_ready, 1);
    chk("ready_after_rst2", if2.cmd_ready, 1);
  endtask

  // Monitor / scoreboard
  logic [3:0] cap_rd [2], cap_wr [2], cap_en [2];
  int         cap_n [2];

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit legal;
      int nz;
      chk("done_pair", s_done[1], s_done[0]);
      for (int d = 0; d < 2; d++) begin
        chk(d == 0 ? "busy4" : "busy2", s_busy[d], (q.size() != 0) || s_done[d]);
        chk(d == 0 ? "err4" : "err2", s_err[d], err_exp[d]);
        legal = 1'b1; nz = 0;
        for (int i = 0; i < 4; i++) begin
          logic [2:0] t3;
          t3 = {s_rd[d][i], s_wr[d][i], s_en[d][i]};
          if (!(t3 inside {3'b000, 3'b011, 3'b100, 3'b111})) legal = 1'b0;
          if (t3 != 3'b000) nz++;
        end
        chk("triple_legal", legal, 1);
        chk("one_reg_active", nz <= 1, 1);
        if (nz != 0) begin
          chk("strobe_has_cmd", q.size() != 0, 1);
          cap_rd[d] = s_rd[d]; cap_wr[d] = s_wr[d]; cap_en[d] = s_en[d];
          cap_n[d]++;
        end
      end
      if ((s_rd[0] | s_wr[0] | s_en[0]) != 0) begin
        prev_stb = last_stb;
        last_stb = cyc;
        for (int i = 0; i < 4; i++)
          if (s_wr[0][i] && s_en[0][i] && !s_rd[0][i]) mreg[i] = s_bus[0];
      end
      if (rst) for (int d = 0; d < 2; d++) begin
        cap_rd[d] = '0; cap_wr[d] = '0; cap_en[d] = '0; cap_n[d] = 0;
      end
      if (s_done[0]) begin
        if (q.size() == 0) chk("done_unexpected", 0, 1);
        else begin
          e = q.pop_front();
          for (int d = 0; d < 2; d++) begin
            chk(d == 0 ? "rdAC4" : "rdAC2", cap_rd[d], e.rd[d]);
            chk(d == 0 ? "wr4" : "wr2", cap_wr[d], e.wr[d]);
            chk(d == 0 ? "en4" : "en2", cap_en[d], e.en[d]);
            chk("single_strobe_cycle", cap_n[d] <= 1, 1);
            chk(d == 0 ? "bus2_4" : "bus2_2", s_bus[d], e.bus);
          end
        end
        for (int d = 0; d < 2; d++) begin
          cap_rd[d] = '0; cap_wr[d] = '0; cap_en[d] = '0; cap_n[d] = 0;
        end
      end
    end
  end

  initial begin
    int a, acc [7];
    for (int d = 0; d < 2; d++) begin
      cap_rd[d] = '0; cap_wr[d] = '0; cap_en[d] = '0; cap_n[d] = 0;
    end
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    drive(1'b0, 2'd0, 2'd0, 8'h00);
    @(negedge clk);
    rst_body();
    mon_en = 1'b1;

    // Single LOAD into an idle issuer: exact latency
    push(2'd1, 2'd1, 8'hA5, a);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      case (k)
        0: begin chk("t1_bus2_e0", if4.bus2_o, 8'h00); chk("t1_done_e0", if4.done, 0); end
        1: begin chk("t1_bus2_e1", if4.bus2_o, 8'hA5); chk("t1_stb_e1", if4.rdAC_o | if4.wr_o | if4.en_o, 0); end
        2: begin chk("t1_wr_e2", if4.wr_o, 4'b0010); chk("t1_en_e2", if4.en_o, 4'b0010);
                 chk("t1_rd_e2", if4.rdAC_o, 4'b0000); chk("t1_done_e2", if4.done, 0); end
        3: begin chk("t1_done_e3", if4.done, 1); chk("t1_stb_e3", if4.rdAC_o | if4.wr_o | if4.en_o, 0);
                 chk("t1_bus2_e3", if4.bus2_o, 8'hA5); end
        default: chk("t1_done_e4", if4.done, 0);
      endcase
    end
    chk("t1_reg1", mreg[1], 8'hA5);
    drain();

    // STORE dst0 then MOVE dst3 back-to-back
    push(2'd2, 2'd0, 8'h11, a);
    push(2'd3, 2'd3, 8'h22, a);
    drain();
    chk("b2b_strobe_gap", last_stb - prev_stb, 3);

    // Fill with valid held: 6 consecutive accepts, 7th waits for a pop
    for (int i = 0; i < 7; i++)
      push(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), acc[i]);
    for (int i = 1; i < 6; i++) chk("fill_consecutive", acc[i] - acc[0], i);
    chk("full_refuse_gap", acc[6] - acc[5], 3);
    drain();

    @(negedge clk);
    rst_body();

    // NOP + out-of-range LOAD on the 2-register issuer; err is sticky
    push(2'd0, 2'd0, 8'h5A, a);
    push(2'd1, 2'd3, 8'hC3, a);
    drain();
    chk("err_sticky2", if2.err, 1);
    chk("err_clear4", if4.err, 0);
    idle(5);
    chk("err_sticky2_later", if2.err, 1);

    // Reset in the STROBE cycle with two commands queued
    push(2'd3, 2'd1, 8'h33, a);
    push(2'd2, 2'd0, 8'h44, a);
    push(2'd1, 2'd1, 8'h55, a);
    @(negedge clk);
    chk("t5_in_strobe", {if4.rdAC_o, if4.wr_o, if4.en_o}, {4'b0010, 4'b0010, 4'b0010});
    rst_body();
    idle(4);
    chk("t5_no_resume", if4.busy, 0);

    // Random command stream
    for (int n = 0; n < 120; n++) begin
      push(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), a);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
